// File: rtl/fir_out_packer.sv
// -----------------------------------------------------------------------------
// fir_out_packer
//
// Output stage of the W4823 FIR. Takes the final FP29i accumulation result
// (sign, 7-bit biased exponent, 22-bit unnormalized magnitude). It normalizes
// the value, rounds it to IEEE FP16 (round-to-nearest-even) and saturates:
// overflow becomes +/-inf and underflow becomes signed zero. The packed result
// is then held on dout, and valid stays high for VALID_HOLD clk_fast cycles so
// that a slower clock domain can sample it.
//
// Pipeline: S1 capture -> S2 normalize -> S3 round/pack into the output
// registers. A result sampled at edge n appears on dout at edge n+2.
//
// Parameters
//   VALID_HOLD : clk_fast cycles valid stays high per result (1..15)
//   BIAS_IN    : FP29i exponent bias
//
// Ports
//   clk_fast  : fast clock; all state changes on the posedge
//   rst_n     : asynchronous active-low reset
//   res_vld   : single-cycle pulse, res_fp29i holds a final result
//   res_fp29i : {sign[29], exp[28:22], mag[21:0]}
//   dout      : FP16 result, held until the next result
//   valid     : high for VALID_HOLD cycles per result
//   ovf       : dout is a saturated +/-inf
//   unf       : dout was flushed to zero from a nonzero input
//   busy      : a pipeline stage is occupied or valid is high
// -----------------------------------------------------------------------------
module fir_out_packer #(
    parameter int VALID_HOLD = 4,
    parameter int BIAS_IN    = 63
) (
    input  logic        clk_fast,
    input  logic        rst_n,
    input  logic        res_vld,
    input  logic [29:0] res_fp29i,
    output logic [15:0] dout,
    output logic        valid,
    output logic        ovf,
    output logic        unf,
    output logic        busy
);

    // The FP16 biased exponent is e + p - (BIAS_IN + 6). The extra 6 comes
    // from moving the binary point 21 places and from the FP16 bias of 15.
    localparam logic signed [8:0] E_OFS = 9'(BIAS_IN + 6);

    // ---------------- S1: capture ----------------
    logic        v1;
    logic        s1;
    logic [6:0]  e1;
    logic [21:0] m1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values its sources held before the edge.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= 1'b0;
            e1 <= '0;
            m1 <= '0;
        end else begin
            v1 <= res_vld;
            if (res_vld) begin
                s1 <= res_fp29i[29];
                e1 <= res_fp29i[28:22];
                m1 <= res_fp29i[21:0];
            end
        end
    end

    // Leading-one position of the captured magnitude. The loop climbs upward,
    // so the last set bit it sees wins.
    logic [4:0] p1;
    logic       z1;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment. A path that leaves a signal unassigned would infer a latch.
    always_comb begin
        p1 = '0;
        for (int i = 0; i < 22; i++) begin
            if (m1[i]) p1 = 5'(i);
        end
        z1 = (m1 == '0);
    end

    // Normalize so the leading one lands on bit 21. That implicit bit is
    // dropped, so only bits [20:0] of the shifted value are kept.
    logic        [20:0] n1;
    logic signed [8:0]  e_norm1;

    always_comb begin
        n1      = 21'(m1 << (5'd21 - p1));
        e_norm1 = $signed({2'b00, e1}) + $signed({4'b0000, p1}) - E_OFS;
    end

    // ---------------- S2: normalized fields ----------------
    logic              v2;
    logic              s2;
    logic              z2;
    logic signed [8:0] e2;
    logic        [9:0] frac2;
    logic              g2;
    logic              st2;

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            s2    <= 1'b0;
            z2    <= 1'b0;
            e2    <= '0;
            frac2 <= '0;
            g2    <= 1'b0;
            st2   <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                s2    <= s1;
                z2    <= z1;
                e2    <= e_norm1;
                frac2 <= n1[20:11];
                g2    <= n1[10];
                st2   <= |n1[9:0];
            end
        end
    end

    // ---------------- S3: round and pack ----------------
    logic              round_up;
    logic [10:0]       frac_rnd;
    logic signed [9:0] e_rnd;
    logic [15:0]       dout_nx;
    logic              ovf_nx;
    logic              unf_nx;

    always_comb begin
        round_up = g2 & (st2 | frac2[0]);
        // A carry out of the fraction leaves frac_rnd[9:0] at zero and bumps
        // the exponent. This is the 1.111..1 -> 10.000..0 case.
        frac_rnd = {1'b0, frac2} + {10'b0, round_up};
        e_rnd    = $signed({e2[8], e2}) + $signed({9'b0, frac_rnd[10]});

        dout_nx  = {s2, e_rnd[4:0], frac_rnd[9:0]};
        ovf_nx   = 1'b0;
        unf_nx   = 1'b0;
        if (z2) begin
            dout_nx = {s2, 15'b0};
        end else if (e_rnd >= 10'sd31) begin
            dout_nx = {s2, 5'h1F, 10'h000};
            ovf_nx  = 1'b1;
        end else if (e_rnd <= 10'sd0) begin
            dout_nx = {s2, 15'b0};
            unf_nx  = 1'b1;
        end
    end

    // ---------------- output registers and valid hold ----------------
    logic [3:0] hold_cnt;

    // NOTE: every register, including the data path, resets to a known value.
    // An abort then leaves nothing stale on dout and no partial valid.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            hold_cnt <= '0;
        end else begin
            if (v2) begin
                dout     <= dout_nx;
                ovf      <= ovf_nx;
                unf      <= unf_nx;
                hold_cnt <= 4'(VALID_HOLD);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        valid = (hold_cnt != '0);
        busy  = v1 | v2 | valid;
    end

endmodule

// File: tb/tb_fir_out_packer.sv
// -----------------------------------------------------------------------------
// tb_fir_out_packer
//
// Directed and random stimulus for fir_out_packer. The reference model
// converts each FP29i word to FP16 using real arithmetic: it scales the value
// into [1,2), rounds the 10-bit fraction to nearest-even, then saturates. The
// model predicts dout/ovf/unf two edges after capture. It also predicts valid
// from the number of cycles since the last write.
// -----------------------------------------------------------------------------
module tb_fir_out_packer;

    localparam int VALID_HOLD = 4;
    localparam int BIAS_IN    = 63;

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic        res_vld;
    logic [29:0] res_fp29i;
    logic [15:0] dout;
    logic        valid;
    logic        ovf;
    logic        unf;
    logic        busy;

    fir_out_packer #(
        .VALID_HOLD(VALID_HOLD),
        .BIAS_IN   (BIAS_IN)
    ) dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .res_vld  (res_vld),
        .res_fp29i(res_fp29i),
        .dout     (dout),
        .valid    (valid),
        .ovf      (ovf),
        .unf      (unf),
        .busy     (busy)
    );

    always #5 clk_fast = ~clk_fast;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: results in flight (index 0 = captured last edge) and the
    // currently presented output.
    bit          p_v [2];
    logic [17:0] p_r [2];   // {ovf, unf, dout}
    logic [15:0] exp_dout;
    logic        exp_ovf;
    logic        exp_unf;
    bit          wrote;
    int          age;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] w(input bit s, input int e, input int m);
        return {s, 7'(e), 22'(m)};
    endfunction

    // FP29i -> FP16 reference conversion, returns {ovf, unf, dout}.
    function automatic logic [17:0] fp16_ref(input logic [29:0] word);
        bit  s;
        int  e;
        int  m;
        int  k;
        int  ip;
        int  biased;
        real mag;
        real scaled;
        real fr;
        s = word[29];
        e = int'(word[28:22]);
        m = int'(word[21:0]);
        if (m == 0) return {2'b00, s, 15'b0};
        // value = m * 2^(e - BIAS_IN - 21) = mag * 2^k with mag in [1,2)
        mag = real'(m);
        k   = e - BIAS_IN - 21;
        while (mag >= 2.0) begin
            mag = mag / 2.0;
            k++;
        end
        scaled = mag * 1024.0;
        ip     = $rtoi(scaled);
        fr     = scaled - real'(ip);
        if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
        if (ip == 2048) begin
            ip = 1024;
            k++;
        end
        biased = k + 15;
        if (biased >= 31) return {2'b10, s, 5'h1F, 10'h000};
        if (biased <= 0)  return {2'b01, s, 15'b0};
        return {2'b00, s, 5'(biased), 10'(ip - 1024)};
    endfunction

    task automatic model_reset();
        p_v[0]   = 1'b0;
        p_v[1]   = 1'b0;
        p_r[0]   = '0;
        p_r[1]   = '0;
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        wrote    = 1'b0;
        age      = 0;
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = wrote && (age < VALID_HOLD);
        check("dout",  dout,  exp_dout);
        check("ovf",   ovf,   exp_ovf);
        check("unf",   unf,   exp_unf);
        check("valid", valid, exp_valid);
        check("busy",  busy,  p_v[0] | p_v[1] | exp_valid);
    endtask

    // One clock cycle: drive inputs, advance the model at the posedge, and
    // compare all outputs on the following negedge.
    task automatic cycle(input bit vld, input logic [29:0] word);
        res_vld   = vld;
        res_fp29i = vld ? word : 30'($urandom);
        @(posedge clk_fast);
        if (p_v[1]) begin
            {exp_ovf, exp_unf, exp_dout} = p_r[1];
            wrote = 1'b1;
            age   = 0;
        end else if (wrote && age < 1000) begin
            age++;
        end
        p_v[1] = p_v[0];
        p_r[1] = p_r[0];
        p_v[0] = vld;
        p_r[0] = fp16_ref(word);
        @(negedge clk_fast);
        res_vld = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    // Send one result, wait until it is presented (edge n+2), compare against
    // the hand-derived FP16 value, then let valid expire.
    task automatic directed(input string tag, input logic [29:0] word,
                            input logic [15:0] exp_d, input bit exp_o, input bit exp_u);
        cycle(1'b1, word);
        idle(2);
        check({tag, "_dout"}, dout, exp_d);
        check({tag, "_ovf"},  ovf,  exp_o);
        check({tag, "_unf"},  unf,  exp_u);
        check({tag, "_vld"},  valid, 1'b1);
        idle(VALID_HOLD + 1);
    endtask

    initial begin
        int vcount;
        model_reset();
        rst_n     = 1'b0;
        res_vld   = 1'b0;
        res_fp29i = '0;

        // Reset state
        #2;
        check("rst_dout",  dout,  16'h0000);
        check("rst_valid", valid, 1'b0);
        check("rst_ovf",   ovf,   1'b0);
        check("rst_unf",   unf,   1'b0);
        check("rst_busy",  busy,  1'b0);
        @(negedge clk_fast);
        @(negedge clk_fast);
        rst_n = 1'b1;
        idle(2);

        // Basic, sign, rounding, LZC extremes, saturation
        directed("one",     w(0, 63, 'h200000), 16'h3C00, 0, 0);
        directed("neg_one", w(1, 63, 'h200000), 16'hBC00, 0, 0);
        directed("tie_even",w(0, 63, 'h200400), 16'h3C00, 0, 0);
        directed("tie_odd", w(0, 63, 'h200C00), 16'h3C02, 0, 0);
        directed("carry",   w(0, 63, 'h3FFC00), 16'h4000, 0, 0);
        directed("lzc_min", w(0, 84, 'h000001), 16'h3C00, 0, 0);
        directed("zero",    w(1, 63, 'h000000), 16'h8000, 0, 0);
        directed("ovf",     w(0, 90, 'h200000), 16'h7C00, 1, 0);
        directed("unf",     w(0, 40, 'h200000), 16'h0000, 0, 1);

        // Valid width: exactly VALID_HOLD cycles for a single result
        cycle(1'b1, w(0, 63, 'h200000));
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0);
            if (valid) vcount++;
        end
        check("valid_width", vcount, VALID_HOLD);

        // Back-to-back: 1.0, 2.0, -1.0, valid continuous until edge n+8
        cycle(1'b1, w(0, 63, 'h200000));   // edge n
        cycle(1'b1, w(0, 64, 'h200000));   // edge n+1
        cycle(1'b1, w(1, 63, 'h200000));   // edge n+2
        check("b2b_0", dout, 16'h3C00);
        cycle(1'b0, '0);                   // edge n+3
        check("b2b_1", dout, 16'h4000);
        cycle(1'b0, '0);                   // edge n+4
        check("b2b_2", dout, 16'hBC00);
        idle(3);                           // edges n+5..n+7
        check("b2b_vld_n7", valid, 1'b1);
        idle(1);                           // edge n+8
        check("b2b_vld_n8", valid, 1'b0);
        idle(2);

        // Reset mid-flight, with an earlier result still being held
        cycle(1'b1, w(0, 63, 'h200000));
        idle(2);
        cycle(1'b1, w(0, 64, 'h200000));   // edge n
        cycle(1'b0, '0);                   // edge n+1
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_dout",  dout,  16'h0000);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_ovf",   ovf,   1'b0);
        check("mid_rst_unf",   unf,   1'b0);
        check("mid_rst_busy",  busy,  1'b0);
        @(negedge clk_fast);
        @(negedge clk_fast);
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0);
            if (valid) vcount++;
        end
        check("mid_rst_no_valid", vcount, 0);

        // Random stream: random gaps, random magnitude widths, exponents
        // spread over the whole range with extra weight near the FP16 window.
        for (int i = 0; i < 600; i++) begin
            bit          vld;
            int          e;
            int          width;
            int          m;
            vld   = ($urandom_range(0, 99) < 55);
            width = $urandom_range(0, 22);
            m     = int'($urandom & ((32'd1 << width) - 32'd1));
            if ($urandom_range(0, 3) == 0) e = $urandom_range(0, 127);
            else                           e = $urandom_range(45, 100);
            cycle(vld, w(1'($urandom), e, m));
        end
        idle(VALID_HOLD + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net: the directed sequence is bounded, but never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_out_packer.md
# fir_out_packer

Output stage of the W4823 FIR, directly downstream of the FPALU accumulator. It accepts the final FP29i accumulation result (sign, 7-bit biased exponent, 22-bit unnormalized magnitude) when the `accnorm` phase completes. It normalizes the value, rounds it to IEEE FP16 with round-to-nearest-even, and saturates overflow to infinity and underflow to signed zero. It then holds `dout` and asserts `valid` for a programmable number of `clk_fast` cycles so the slow `clk1` domain can sample it.

## Interface
- `VALID_HOLD`, 4: number of `clk_fast` cycles `valid` stays high per result. Legal range 1..15.
- `BIAS_IN`, 63: FP29i exponent bias.
- `clk_fast` input 1: fast clock; all state changes on the posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `res_vld` input 1: single-cycle pulse marking that `res_fp29i` holds a final result.
- `res_fp29i` input 30: bit 29 is the sign, [28:22] the exponent e, [21:0] the magnitude m. Value = (−1)^s × m × 2^(e − BIAS_IN − 21).
- `dout` output 16: FP16 result, held until the next result.
- `valid` output 1: high for `VALID_HOLD` cycles per result.
- `ovf` output 1: the current `dout` is a saturated ±inf. Updates together with `dout`.
- `unf` output 1: the current `dout` was flushed to zero from a nonzero input. Updates together with `dout`.
- `busy` output 1: high while any pipeline stage is occupied or `valid` is high.

## Operation
- **Stage S1 (capture).** On a posedge with `res_vld`=1, register s, e and m, and set `v1`. Compute p, the index of the leading one in m (0..21), with a 22-bit leading-zero counter. Set a zero flag if m==0.
- **Stage S2 (normalize).**
  - n = m << (21−p), so n[21]=1.
  - E = e + p − (BIAS_IN + 6), computed as a 9-bit signed value. For BIAS_IN=63 this is e + p − 69.
  - frac = n[20:11], guard g = n[10], sticky st = |n[9:0].
- **Stage S3 (round/pack), registered into the output.**
  - Round up if g & (st | frac[0]).
  - If frac=0x3FF and a round-up occurs: frac becomes 0 and E becomes E+1.
  - Apply the first matching rule, using E after rounding:
    - m==0: dout = {s,15'b0}, ovf=0, unf=0.
    - E ≥ 31: dout = {s,5'h1F,10'h0}, ovf=1.
    - E ≤ 0: dout = {s,15'b0}, unf=1. Subnormals are not generated.
    - Otherwise: dout = {s,E[4:0],frac}, ovf=0, unf=0.
- The pipeline is fully pipelined: `res_vld` may be asserted on every cycle, and each accepted result reaches `dout` in order.
- **Valid counter.**
  - A 4-bit `hold_cnt` loads `VALID_HOLD` when S3 writes; `valid` = (`hold_cnt` != 0).
  - While nonzero and not reloading, the counter decrements each cycle.
  - A new write while `valid` is high overwrites `dout`/`ovf`/`unf` and reloads the counter. `valid` stays high with no gap.
- **Reset values:** `dout`=0, `valid`=0, `ovf`=0, `unf`=0, `busy`=0, all stage valids=0, `hold_cnt`=0.
- **Reset mid-operation:** results in flight are discarded, with no partial `valid`.

## Timing
- With `res_vld` sampled at edge n, `dout`/`ovf`/`unf` update and `valid` rises at edge n+2.
- `valid` falls at edge n+2+VALID_HOLD, unless reloaded by a later result.
- `busy` rises at edge n and falls at the edge where `valid` falls, provided no new `res_vld` arrives.
- `res_fp29i` is required to be stable only during the `res_vld` cycle.
- `res_fp29i` is ignored when `res_vld`=0.
- No combinational path exists from inputs to outputs.

## Test plan
- **Basic and sign:** e=63, m=0x200000, s=0 → `dout`=0x3C00 at edge n+2. The same with s=1 → 0xBC00. `valid` is high for exactly 4 cycles.
- **Rounding:**
  - m=0x200400 (tie, even LSB) → 0x3C00.
  - m=0x200C00 (tie, odd LSB) → 0x3C02.
  - m=0x3FFC00 (carry-out) → 0x4000.
- **LZC extremes:** e=84, m=0x000001 → 0x3C00. m=0 with s=1 → 0x8000, ovf=0, unf=0.
- **Saturation:** e=90, m=0x200000 → 0x7C00 with ovf=1. e=40, m=0x200000 → 0x0000 with unf=1.
- **Back-to-back:** `res_vld` on 3 consecutive cycles with values 1.0, 2.0 and −1.0 gives `dout` = 0x3C00, 0x4000, 0xBC00 on edges n+2 through n+4. `valid` is continuously high until edge n+8.
- **Reset mid-flight:** assert `rst_n`=0 one cycle after `res_vld`. All outputs read 0 immediately, and no `valid` occurs after release.
